// File: rtl/if_stage.sv
// if_stage: RV32I instruction-fetch stage.
// Owns the fetch PC, issues word requests to instruction memory, buffers
// in-order responses in a small queue and drives the IF/ID register.
// Optional build macro IF_PERF_EN adds saturating performance counters
// (perf_fetched, perf_stall, perf_dropped).
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_ID,
    input  logic        redirect_Ex,
    input  logic [31:0] redirect_pc_Ex,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [15:0] perf_dropped
`endif
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [31:0]   pc_id_q, pc_id_d;
    logic [31:0]   inst_id_q, inst_id_d;
    logic          valid_id_q, valid_id_d;

    logic [31:0]   qpc_q   [BUF_DEPTH];
    logic [31:0]   qinst_q [BUF_DEPTH];

    logic          room;
    logic          hs;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          push;
    logic          pop;
    logic          load;
    logic [31:0]   redir_tgt;

    // Space is reserved at request time: in-flight plus buffered never exceeds
    // BUF_DEPTH, so every accepted response has a queue slot waiting for it.
    assign room      = (out_q + cnt_q) < CW'(BUF_DEPTH);
    assign imem_req  = reset & room & ~redirect_Ex;
    assign imem_addr = fetch_pc_q;
    assign hs        = imem_req & imem_ready;
    assign redir_tgt = redirect_pc_Ex & ~32'h3;

    // A response is stale if older drops are pending or a redirect lands with it.
    assign rsp_drop  = imem_rvalid & ((drop_q != '0) | redirect_Ex);
    assign rsp_keep  = imem_rvalid & ~rsp_drop;

    assign pc_ID     = pc_id_q;
    assign inst_ID   = inst_id_q;
    assign valid_ID  = valid_id_q;

    // Next-state: PC tracking, in-flight/drop accounting, queue and IF/ID update.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q + CW'(hs) - CW'(imem_rvalid);
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        pc_id_d    = pc_id_q;
        inst_id_d  = inst_id_q;
        valid_id_d = valid_id_q;
        push       = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;

        if (hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect_Ex) begin
            fetch_pc_d = redir_tgt;
            resp_pc_d  = redir_tgt;
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            drop_d     = out_q - CW'(imem_rvalid);
            valid_id_d = 1'b0;
            inst_id_d  = NOP_INST;
        end else begin
            if (imem_rvalid && drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (!stall_ID) begin
                if (cnt_q != '0) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    pc_id_d    = qpc_q[rd_q];
                    inst_id_d  = qinst_q[rd_q];
                    valid_id_d = 1'b1;
                end else if (rsp_keep) begin
                    // Bypass: empty queue and advancing register take the response directly.
                    load       = 1'b1;
                    pc_id_d    = resp_pc_q;
                    inst_id_d  = imem_rdata;
                    valid_id_d = 1'b1;
                end else begin
                    valid_id_d = 1'b0;
                    inst_id_d  = NOP_INST;
                end
            end
            push = rsp_keep & ~(stall_ID == 1'b0 && cnt_q == '0);
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            if (push) begin
                wr_d = wr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Control and IF/ID state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            pc_id_q    <= '0;
            inst_id_q  <= NOP_INST;
            valid_id_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            pc_id_q    <= pc_id_d;
            inst_id_q  <= inst_id_d;
            valid_id_q <= valid_id_d;
        end
    end

    // Queue storage; contents are qualified by cnt_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            qpc_q[wr_q]   <= resp_pc_q;
            qinst_q[wr_q] <= imem_rdata;
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;
    logic [15:0] perf_dropped_q;

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    assign perf_dropped = perf_dropped_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_dropped_q <= '0;
        end else begin
            if (load && perf_fetched_q != '1) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (stall_ID && valid_id_q && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (rsp_drop && perf_dropped_q != '1) begin
                perf_dropped_q <= perf_dropped_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: in-order memory model with variable
// latency, a scoreboard of expected IF/ID beats filled at request acceptance,
// directed sequences for latency/stall/ready/async-reset, and a table of
// redirect scenarios.
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned BUF_DEPTH = 2;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall_ID;
    logic        redirect_Ex;
    logic [31:0] redirect_pc_Ex;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_ID;
    logic [31:0] inst_ID;
    logic        valid_ID;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [15:0] perf_dropped;
`endif

    if_stage #(
        .RESET_PC (RESET_PC),
        .BUF_DEPTH(BUF_DEPTH),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_ID      (stall_ID),
        .redirect_Ex   (redirect_Ex),
        .redirect_pc_Ex(redirect_pc_Ex),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .pc_ID         (pc_ID),
        .inst_ID       (inst_ID),
        .valid_ID      (valid_ID)
`ifdef IF_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall),
        .perf_dropped  (perf_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } beat_t;

    typedef struct packed {
        logic [31:0] lat;
        logic [31:0] pre;
        logic        stall;
        logic [31:0] target;
        logic [31:0] exp_pc0;
    } vec_t;

    pend_t       pend[$];
    beat_t       expq[$];
    int          n_tests;
    int          n_fail;
    logic [31:0] cyc;
    logic [31:0] lat;
    logic [31:0] exp_fetch;
    logic        s_stall, s_red;
    logic [31:0] s_tgt;
    logic        last_req;
    logic [31:0] last_addr;
    logic        beat_seen;
    logic [31:0] beat_pc;
    logic [31:0] beats;
    logic [31:0] n_stale;
    logic [31:0] prev_pc, prev_inst;
    logic        prev_valid;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h0019_660D) ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic save_prev();
        prev_pc    = pc_ID;
        prev_inst  = inst_ID;
        prev_valid = valid_ID;
    endtask

    // One clock cycle: sample handshake at negedge, check after posedge, drive memory.
    task automatic step();
        pend_t p;
        beat_t b;
        @(negedge clk);
        s_stall   = stall_ID;
        s_red     = redirect_Ex;
        s_tgt     = redirect_pc_Ex;
        last_req  = imem_req;
        last_addr = imem_addr;
        if (s_red) begin
            chk("redir_noreq", 32'(imem_req), 32'd0);
            n_stale = 32'(pend.size()) + 32'(imem_rvalid);
        end
        if (imem_req && imem_ready) begin
            chk("req_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            p.addr = imem_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            b.pc   = imem_addr;
            b.inst = mw(imem_addr);
            expq.push_back(b);
        end
        chk("no_overflow", 32'(pend.size()) + 32'(imem_rvalid) <= BUF_DEPTH, 32'd1);
        @(posedge clk);
        cyc = cyc + 32'd1;
        #1;
        beat_seen = 1'b0;
        if (s_red) begin
            chk("redir_valid", 32'(valid_ID), 32'd0);
            chk("redir_inst", inst_ID, NOP_INST);
            expq.delete();
            exp_fetch = {s_tgt[31:2], 2'b00};
        end else if (s_stall) begin
            chk("stall_pc", pc_ID, prev_pc);
            chk("stall_inst", inst_ID, prev_inst);
            chk("stall_valid", 32'(valid_ID), 32'(prev_valid));
        end else if (valid_ID) begin
            beat_seen = 1'b1;
            beat_pc   = pc_ID;
            beats     = beats + 32'd1;
            if (expq.size() == 0) begin
                chk("beat_expected", 32'd0, 32'd1);
            end else begin
                b = expq.pop_front();
                chk("beat_pc", pc_ID, b.pc);
                chk("beat_inst", inst_ID, b.inst);
            end
        end
        save_prev();
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mw(p.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        stall_ID       = 1'b0;
        redirect_Ex    = 1'b0;
        redirect_pc_Ex = '0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        pend.delete();
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(valid_ID), 32'd0);
        chk("rst_inst", inst_ID, NOP_INST);
        chk("rst_pc", pc_ID, 32'd0);
        reset     = 1'b1;
        exp_fetch = RESET_PC;
        beats     = '0;
        save_prev();
    endtask

    task automatic run_until_beat(input string name, output logic [31:0] pc);
        logic got;
        got = 1'b0;
        pc  = '0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (beat_seen) begin
                got = 1'b1;
                pc  = beat_pc;
            end
        end
        if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        logic [31:0] pc0;
        logic [31:0] a0;
        logic        r0;
        logic        ok;
        n_tests = 0;
        n_fail  = 0;
        cyc     = '0;
        lat     = 32'd1;
        n_stale = '0;
        beats   = '0;

        vecs[0] = '{lat: 32'd3, pre: 32'd4, stall: 1'b0, target: 32'h0000_0100, exp_pc0: 32'h0000_0100};
        vecs[1] = '{lat: 32'd3, pre: 32'd5, stall: 1'b1, target: 32'h0000_0200, exp_pc0: 32'h0000_0200};
        vecs[2] = '{lat: 32'd1, pre: 32'd5, stall: 1'b0, target: 32'h0000_0303, exp_pc0: 32'h0000_0300};
        vecs[3] = '{lat: 32'd2, pre: 32'd3, stall: 1'b1, target: 32'hFFFF_FFF8, exp_pc0: 32'hFFFF_FFF8};
        vecs[4] = '{lat: 32'd1, pre: 32'd0, stall: 1'b0, target: 32'h0000_0040, exp_pc0: 32'h0000_0040};

        // Latency-1 streaming from reset: first beat two cycles after release.
        do_reset();
        lat = 32'd1;
        step();
        chk("lat_req0", 32'(last_req), 32'd1);
        chk("lat_addr0", last_addr, 32'h0);
        chk("lat_not_yet", 32'(valid_ID), 32'd0);
        step();
        chk("lat_addr1", last_addr, 32'h4);
        chk("first_valid", 32'(valid_ID), 32'd1);
        chk("first_pc", pc_ID, 32'h0);
        step();
        chk("lat_addr2", last_addr, 32'h8);
        chk("second_pc", pc_ID, 32'h4);

        // Stall for 3 cycles while pc_ID=0x8; queue fills and requests stop.
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (valid_ID && pc_ID == 32'h8) ok = 1'b1;
            else step();
        end
        chk("stall_setup", 32'(ok), 32'd1);
        stall_ID = 1'b1;
        step();
        step();
        step();
        chk("stall_hold_pc8", pc_ID, 32'h8);
        chk("req_full", 32'(last_req), 32'd0);
        stall_ID = 1'b0;
        step();
        chk("resume_pc_c", pc_ID, 32'hC);
        step();
        chk("resume_pc_10", pc_ID, 32'h10);

        // imem_ready 1,0,0,1: request held stable while not accepted.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        a0 = last_addr;
        r0 = last_req;
        chk("ready_req_pending", 32'(r0), 32'd1);
        step();
        chk("ready_hold_addr", last_addr, a0);
        chk("ready_hold_req", 32'(last_req), 32'(r0));
        imem_ready = 1'b1;
        step();
        chk("ready_accept_addr", last_addr, a0);
        repeat (4) step();

        // Asynchronous reset mid-cycle with two requests outstanding.
        do_reset();
        lat = 32'd3;
        ok  = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            if (pend.size() == 2) ok = 1'b1;
        end
        chk("areset_setup", 32'(ok), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_req", 32'(imem_req), 32'd0);
        chk("areset_valid", 32'(valid_ID), 32'd0);
        chk("areset_inst", inst_ID, NOP_INST);
        chk("areset_pc", pc_ID, 32'd0);
        do_reset();
        lat = 32'd1;
        run_until_beat("areset_resume", pc0);
        chk("areset_resume_pc", pc0, RESET_PC);
        repeat (3) step();

        // Redirect scenarios, including stall+redirect, misaligned target and PC wrap.
        foreach (vecs[k]) begin
            do_reset();
            lat = vecs[k].lat;
            for (int i = 0; i < int'(vecs[k].pre); i++) step();
            redirect_Ex    = 1'b1;
            redirect_pc_Ex = vecs[k].target;
            stall_ID       = vecs[k].stall;
            step();
            redirect_Ex    = 1'b0;
            redirect_pc_Ex = '0;
            stall_ID       = 1'b0;
            run_until_beat("redir_first", pc0);
            chk("redir_target", pc0, vecs[k].exp_pc0);
            repeat (6) step();
`ifdef IF_PERF_EN
            chk("perf_dropped", 32'(perf_dropped), n_stale);
            chk("perf_fetched", perf_fetched, beats);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline, directly upstream of the decode stage.
- Owns the fetch PC and issues word requests to instruction memory over a request/response handshake.
- Buffers returned instructions in a small in-order queue and drives the IF/ID pipeline register (pc_ID, inst_ID, valid_ID).
- Honours decode stalls and EX-stage branch/jump redirects; discards stale in-flight responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, fetch-queue entries; also the maximum number of outstanding memory requests (power of two, ≥2).
- NOP_INST, 32'h0000_0013, instruction driven on inst_ID when valid_ID=0 (ADDI x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- stall_ID  in  1  decode cannot accept; hold IF/ID register.
- redirect_Ex  in  1  taken branch/jump resolved in EX.
- redirect_pc_Ex  in  32  target PC for redirect.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned request address.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid; responses return in order, latency ≥1 cycle.
- imem_rdata  in  32  instruction word.
- pc_ID  out  32  PC of instruction in IF/ID register.
- inst_ID  out  32  instruction in IF/ID register.
- valid_ID  out  1  IF/ID register holds a real instruction.

Behaviour:
- Reset (reset=0, asynchronous): fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; pc_ID=0; inst_ID=NOP_INST; valid_ID=0; imem_req=0 while reset asserted.
- Request issue: imem_req=1 when (outstanding + queue count) < BUF_DEPTH and redirect_Ex=0. imem_addr=fetch_pc. Handshake completes when imem_req and imem_ready are both 1. On handshake: fetch_pc += 4 and outstanding += 1. imem_req and imem_addr stay stable until accepted.
- Response: on imem_rvalid, outstanding -= 1.
  - If drop_cnt > 0: decrement drop_cnt and discard the data.
  - Otherwise: push {resp_pc, imem_rdata} into the queue. resp_pc is a separate counter incremented per accepted response.
- Space reservation: outstanding + count ≤ BUF_DEPTH at all times, so a response push never overflows. Response overflow is impossible by construction; the bench asserts it.
- IF/ID register update (posedge):
  - redirect_Ex=1 has priority over everything: valid_ID<=0, inst_ID<=NOP_INST, pc_ID held.
  - Else if stall_ID=1: all three outputs hold.
  - Else if queue non-empty: pop head; pc_ID/inst_ID <= head; valid_ID<=1.
  - Else: valid_ID<=0, inst_ID<=NOP_INST.
- Bypass: a response arriving into an empty queue while the IF/ID register can advance is written directly to IF/ID that cycle. Fetch-to-valid_ID latency is memory latency + 1 cycle.
- Redirect (redirect_Ex=1 at posedge):
  - fetch_pc<=redirect_pc_Ex; resp_pc<=redirect_pc_Ex.
  - Queue flushed.
  - drop_cnt<=outstanding minus any response consumed that cycle. A same-cycle response counts as dropped.
  - No request is issued in the redirect cycle.
  - redirect_pc_Ex[1:0] is ignored (forced to 0).
- Simultaneous stall_ID and redirect_Ex: redirect wins.
- Simultaneous push and pop on a full queue: allowed, count unchanged.
- Pointers wrap modulo BUF_DEPTH; the full/empty decision uses a count register.
- fetch_pc wraps 0xFFFF_FFFC → 0x0000_0000 without error.
- Reset mid-transaction: all state clears immediately. Responses arriving after reset release are not dropped; the memory must also be reset by the same signal.

Optional Feature:
- Macro IF_PERF_EN.
- When defined, add outputs:
  - perf_fetched (32-bit): counts instructions loaded into IF/ID with valid_ID=1.
  - perf_stall (32-bit): counts cycles with stall_ID=1 and valid_ID=1.
  - perf_dropped (16-bit): counts discarded responses.
- All counters reset to 0, saturate at all-ones, and do not wrap.
- When not defined, these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, memory latency 1, imem_ready=1, no stall → imem_addr 0x0,0x4,0x8 on consecutive cycles; valid_ID=1 with pc_ID=0x0 on cycle 3 after reset release, then +4 each cycle.
- stall_ID=1 for 3 cycles while pc_ID=0x8 → pc_ID/inst_ID hold 0x8. After the queue fills (2 entries), imem_req=0. After release, pc_ID steps 0xC,0x10 with no gap or duplicate.
- Memory latency 3, two requests outstanding, redirect_Ex=1 to 0x100 → both stale responses dropped; next valid_ID shows pc_ID=0x100 with imem_rdata from address 0x100. With IF_PERF_EN, perf_dropped=2.
- redirect_Ex and stall_ID asserted together → next cycle valid_ID=0, inst_ID=0x0000_0013; fetch restarts at the target.
- imem_ready toggling 1,0,0,1 → imem_addr/imem_req stable while ready=0; no PC skipped.
- Asynchronous reset asserted mid-cycle with outstanding=2 → outputs are reset values immediately (before next clk edge); fetch resumes at RESET_PC.
